// File: rtl/mem_port_arbiter_if.sv
// Bus bundle for the shared memory port: fetch requester, data requester,
// memory-side signals and the busy flag. The arbiter connects via the slave
// modport; the environment (requesters plus memory) uses the master modport.
interface mem_port_arbiter_if #(
  parameter int ADDR_W = 16,
  parameter int DATA_W = 16
);
  // fetch requester
  logic              if_req;
  logic [ADDR_W-1:0] if_addr;
  logic              if_gnt;
  logic              if_valid;
  logic [DATA_W-1:0] if_rdata;

  // data requester
  logic              dm_req;
  logic              dm_we;
  logic [ADDR_W-1:0] dm_addr;
  logic [DATA_W-1:0] dm_wdata;
  logic              dm_gnt;
  logic              dm_valid;
  logic [DATA_W-1:0] dm_rdata;

  // memory port
  logic              mem_en;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic [DATA_W-1:0] mem_rdata;

  logic              busy;

  modport slave (
    input  if_req, if_addr,
    input  dm_req, dm_we, dm_addr, dm_wdata,
    input  mem_rdata,
    output if_gnt, if_valid, if_rdata,
    output dm_gnt, dm_valid, dm_rdata,
    output mem_en, mem_we, mem_addr, mem_wdata,
    output busy
  );

  modport master (
    output if_req, if_addr,
    output dm_req, dm_we, dm_addr, dm_wdata,
    output mem_rdata,
    input  if_gnt, if_valid, if_rdata,
    input  dm_gnt, dm_valid, dm_rdata,
    input  mem_en, mem_we, mem_addr, mem_wdata,
    input  busy
  );
endinterface

// File: rtl/mem_port_arbiter.sv
// Arbiter for the single memory port shared by instruction fetch (IF) and
// data access (DM). Each access runs for MEM_LAT cycles, then the owner gets
// a one-cycle valid pulse. DM wins ties, but only MAX_DM_STREAK times in a row
// while IF is waiting, so fetch can never starve.
//
//   state     | meaning
//   ----------+---------------------------------------------------------
//   ST_IDLE   | port free; grant decided combinationally from requests
//   ST_ACCESS | memory cycles for captured access; cnt counts down to 0
//   ST_RESP   | owner's valid pulse; returns to idle next cycle
module mem_port_arbiter #(
  parameter int ADDR_W        = 16,
  parameter int DATA_W        = 16,
  parameter int MEM_LAT       = 2,
  parameter int MAX_DM_STREAK = 3
) (
  input  logic              clk,
  input  logic              rst,
  mem_port_arbiter_if.slave bus
);

  localparam int CNT_W = (MEM_LAT > 1) ? $clog2(MEM_LAT) : 1;
  localparam int STK_W = (MAX_DM_STREAK > 0) ? $clog2(MAX_DM_STREAK + 1) : 1;
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(MEM_LAT - 1);
  localparam logic [STK_W-1:0] STK_MAX  = STK_W'(MAX_DM_STREAK);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACCESS = 2'd1,
    ST_RESP   = 2'd2
  } state_t;

  state_t            state_q, state_d;
  logic              grant_if, grant_dm;
  logic              owner_dm_q;
  logic              we_q;
  logic [ADDR_W-1:0] addr_q;
  logic [DATA_W-1:0] wdata_q;
  logic [CNT_W-1:0]  cnt_q;
  logic [STK_W-1:0]  streak_q;
  logic [DATA_W-1:0] if_rdata_q;
  logic [DATA_W-1:0] dm_rdata_q;

  // Grant decision in IDLE; suppressed while rst is high so no pulse leaks out.
  always_comb begin
    grant_if = 1'b0;
    grant_dm = 1'b0;
    if (state_q == ST_IDLE && !rst) begin
      if (bus.dm_req && !(bus.if_req && streak_q == STK_MAX)) begin
        grant_dm = 1'b1;
      end else if (bus.if_req) begin
        grant_if = 1'b1;
      end
    end
  end

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:   if (grant_if || grant_dm) state_d = ST_ACCESS;
      ST_ACCESS: if (cnt_q == '0)          state_d = ST_RESP;
      ST_RESP:                             state_d = ST_IDLE;
      default:                             state_d = ST_IDLE;
    endcase
  end

  // Capture the granted access, count down its latency, latch read data on the last cycle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      owner_dm_q <= 1'b0;
      we_q       <= 1'b0;
      addr_q     <= '0;
      wdata_q    <= '0;
      cnt_q      <= '0;
      if_rdata_q <= '0;
      dm_rdata_q <= '0;
    end else if (grant_if || grant_dm) begin
      owner_dm_q <= grant_dm;
      we_q       <= grant_dm && bus.dm_we;
      addr_q     <= grant_dm ? bus.dm_addr : bus.if_addr;
      wdata_q    <= grant_dm ? bus.dm_wdata : '0;
      cnt_q      <= CNT_LOAD;
    end else if (state_q == ST_ACCESS) begin
      if (cnt_q != '0) begin
        cnt_q <= cnt_q - CNT_W'(1);
      end else if (owner_dm_q) begin
        // Stores leave the last load data visible.
        if (!we_q) dm_rdata_q <= bus.mem_rdata;
      end else begin
        if_rdata_q <= bus.mem_rdata;
      end
    end
  end

  // DM-priority streak: counts DM wins over a waiting IF, saturating at the limit.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      streak_q <= '0;
    end else if (grant_if) begin
      streak_q <= '0;
    end else if (grant_dm) begin
      if (bus.if_req) begin
        if (streak_q != STK_MAX) streak_q <= streak_q + STK_W'(1);
      end else begin
        streak_q <= '0;
      end
    end
  end

  // Outputs decoded from state; memory bus is driven only during ACCESS.
  always_comb begin
    bus.if_gnt    = grant_if;
    bus.dm_gnt    = grant_dm;
    bus.if_valid  = 1'b0;
    bus.dm_valid  = 1'b0;
    bus.mem_en    = 1'b0;
    bus.mem_we    = 1'b0;
    bus.mem_addr  = '0;
    bus.mem_wdata = '0;
    bus.busy      = 1'b0;
    bus.if_rdata  = if_rdata_q;
    bus.dm_rdata  = dm_rdata_q;
    case (state_q)
      ST_ACCESS: begin
        bus.mem_en    = 1'b1;
        bus.mem_we    = we_q && (cnt_q == CNT_LOAD);
        bus.mem_addr  = addr_q;
        bus.mem_wdata = wdata_q;
        bus.busy      = 1'b1;
      end
      ST_RESP: begin
        bus.if_valid = !owner_dm_q;
        bus.dm_valid = owner_dm_q;
        bus.busy     = 1'b1;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Self-checking bench for mem_port_arbiter. The memory is modelled as a fixed
// function of address; expected read data is queued when an access is granted
// and popped when the matching valid pulse appears. Inputs change on the falling
// edge and outputs are sampled 1 ns later, before the next rising edge.
module tb_mem_port_arbiter;
  localparam int ADDR_W        = 16;
  localparam int DATA_W        = 16;
  localparam int MEM_LAT       = 2;
  localparam int MAX_DM_STREAK = 3;

  logic clk = 1'b0;
  logic rst;
  int   checks   = 0;
  int   failures = 0;

  typedef struct {
    logic        is_dm;
    logic [15:0] data;
  } exp_t;

  exp_t        sb_q[$];
  logic        ord_q[$];
  logic [15:0] last_dm_rdata;
  logic [70:0] outs;

  mem_port_arbiter_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

  mem_port_arbiter #(
    .ADDR_W(ADDR_W), .DATA_W(DATA_W), .MEM_LAT(MEM_LAT), .MAX_DM_STREAK(MAX_DM_STREAK)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus.slave)
  );

  always #5 clk = ~clk;

  function automatic logic [15:0] rd_val(input logic [15:0] a);
    return a ^ 16'hA5D3;
  endfunction

  assign bus.mem_rdata = rd_val(bus.mem_addr);

  assign outs = {bus.if_gnt, bus.if_valid, bus.if_rdata, bus.dm_gnt, bus.dm_valid,
                 bus.dm_rdata, bus.mem_en, bus.mem_we, bus.mem_addr, bus.mem_wdata, bus.busy};

  task automatic test_reset();
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      bus.if_req   = 1'($urandom_range(0, 1));
      bus.dm_req   = 1'($urandom_range(0, 1));
      bus.dm_we    = 1'($urandom_range(0, 1));
      bus.if_addr  = 16'($urandom);
      bus.dm_addr  = 16'($urandom);
      bus.dm_wdata = 16'($urandom);
      #1;
      checks++;
      if (outs !== 71'd0) begin
        failures++;
        $display("FAIL reset_outputs: got %h expected 0", outs);
      end
    end
    @(negedge clk);
    bus.if_req = 1'b0;
    bus.dm_req = 1'b0;
    rst        = 1'b0;
    last_dm_rdata = 16'h0000;
    for (int i = 0; i < 3; i++) begin
      #1;
      checks++;
      if (outs !== 71'd0) begin
        failures++;
        $display("FAIL idle_after_reset: got %h expected 0", outs);
      end
      @(negedge clk);
    end
  endtask

  task automatic test_if_fetch();
    exp_t e;
    logic we_seen;
    we_seen = 1'b0;
    bus.if_req  = 1'b1;
    bus.if_addr = 16'h0010;
    #1;
    checks++;
    if ({bus.if_gnt, bus.dm_gnt, bus.busy} !== 3'b100) begin
      failures++;
      $display("FAIL fetch_gnt: got if/dm/busy=%b expected 100", {bus.if_gnt, bus.dm_gnt, bus.busy});
    end
    sb_q.push_back('{1'b0, 16'hA5C3});
    for (int k = 1; k <= MEM_LAT; k++) begin
      @(negedge clk);
      bus.if_req  = 1'b0;
      bus.if_addr = 16'hFFFF;
      #1;
      if (bus.mem_we) we_seen = 1'b1;
      checks++;
      if (bus.mem_en !== 1'b1 || bus.mem_addr !== 16'h0010 || bus.busy !== 1'b1 || bus.if_valid !== 1'b0) begin
        failures++;
        $display("FAIL fetch_access%0d: got en=%b addr=%h busy=%b valid=%b expected 1 0010 1 0",
                 k, bus.mem_en, bus.mem_addr, bus.busy, bus.if_valid);
      end
    end
    @(negedge clk);
    #1;
    checks++;
    if (bus.if_valid !== 1'b1 || bus.dm_valid !== 1'b0 || bus.mem_en !== 1'b0) begin
      failures++;
      $display("FAIL fetch_valid: got if_valid=%b dm_valid=%b mem_en=%b expected 1 0 0",
               bus.if_valid, bus.dm_valid, bus.mem_en);
    end else begin
      e = sb_q.pop_front();
      checks++;
      if (bus.if_rdata !== e.data) begin
        failures++;
        $display("FAIL fetch_rdata: got %h expected %h", bus.if_rdata, e.data);
      end
    end
    @(negedge clk);
    #1;
    checks++;
    if (bus.if_valid !== 1'b0 || bus.busy !== 1'b0 || we_seen !== 1'b0) begin
      failures++;
      $display("FAIL fetch_done: got valid=%b busy=%b we_seen=%b expected 0 0 0",
               bus.if_valid, bus.busy, we_seen);
    end
  endtask

  task automatic test_store();
    exp_t e;
    @(negedge clk);
    bus.dm_req   = 1'b1;
    bus.dm_we    = 1'b1;
    bus.dm_addr  = 16'h0200;
    bus.dm_wdata = 16'h1234;
    #1;
    checks++;
    if ({bus.dm_gnt, bus.if_gnt} !== 2'b10) begin
      failures++;
      $display("FAIL store_gnt: got dm/if=%b expected 10", {bus.dm_gnt, bus.if_gnt});
    end
    sb_q.push_back('{1'b1, last_dm_rdata});
    for (int k = 1; k <= MEM_LAT; k++) begin
      @(negedge clk);
      bus.dm_req   = 1'b0;
      bus.dm_we    = 1'b0;
      bus.dm_wdata = 16'hDEAD;
      #1;
      checks++;
      if (bus.mem_we !== (k == 1) || bus.mem_en !== 1'b1 || bus.mem_addr !== 16'h0200 || bus.mem_wdata !== 16'h1234) begin
        failures++;
        $display("FAIL store_access%0d: got we=%b en=%b addr=%h wdata=%h expected we=%b 1 0200 1234",
                 k, bus.mem_we, bus.mem_en, bus.mem_addr, bus.mem_wdata, (k == 1));
      end
    end
    @(negedge clk);
    #1;
    checks++;
    if (bus.dm_valid !== 1'b1 || bus.if_valid !== 1'b0) begin
      failures++;
      $display("FAIL store_valid: got dm_valid=%b if_valid=%b expected 1 0", bus.dm_valid, bus.if_valid);
    end else begin
      e = sb_q.pop_front();
      checks++;
      if (bus.dm_rdata !== e.data) begin
        failures++;
        $display("FAIL store_rdata_kept: got %h expected %h", bus.dm_rdata, e.data);
      end
    end
  endtask

  task automatic test_streak();
    exp_t e;
    int   gcount;
    int   vcount;
    gcount = 0;
    vcount = 0;
    for (int i = 0; i < 2; i++) begin
      ord_q.push_back(1'b1);
      ord_q.push_back(1'b1);
      ord_q.push_back(1'b1);
      ord_q.push_back(1'b0);
    end
    bus.dm_we   = 1'b0;
    bus.if_addr = 16'h0100;
    bus.dm_addr = 16'h0300;
    for (int cyc = 0; cyc < 80 && vcount < 8; cyc++) begin
      @(negedge clk);
      bus.if_req = (gcount < 8);
      bus.dm_req = (gcount < 8);
      #1;
      if (bus.if_gnt || bus.dm_gnt) begin
        checks++;
        if (ord_q.size() == 0 || (bus.if_gnt && bus.dm_gnt) || bus.dm_gnt !== ord_q[0]) begin
          failures++;
          $display("FAIL streak_order%0d: got if_gnt=%b dm_gnt=%b expected dm_gnt=%b",
                   gcount, bus.if_gnt, bus.dm_gnt, (ord_q.size() != 0) ? ord_q[0] : 1'bx);
        end
        if (ord_q.size() != 0) void'(ord_q.pop_front());
        sb_q.push_back('{bus.dm_gnt, rd_val(bus.dm_gnt ? 16'h0300 : 16'h0100)});
        gcount++;
      end
      if (bus.if_valid || bus.dm_valid) begin
        checks++;
        if (sb_q.size() == 0) begin
          failures++;
          $display("FAIL streak_data%0d: got unexpected valid if=%b dm=%b expected none", vcount, bus.if_valid, bus.dm_valid);
        end else begin
          e = sb_q.pop_front();
          if (bus.dm_valid !== e.is_dm || bus.if_valid === e.is_dm ||
              (e.is_dm ? bus.dm_rdata : bus.if_rdata) !== e.data) begin
            failures++;
            $display("FAIL streak_data%0d: got if_valid=%b dm_valid=%b if_rdata=%h dm_rdata=%h expected owner_dm=%b data=%h",
                     vcount, bus.if_valid, bus.dm_valid, bus.if_rdata, bus.dm_rdata, e.is_dm, e.data);
          end
        end
        vcount++;
      end
    end
    checks++;
    if (gcount != 8 || vcount != 8) begin
      failures++;
      $display("FAIL streak_timeout: got grants=%0d valids=%0d expected 8 8", gcount, vcount);
    end
    ord_q.delete();
    sb_q.delete();
    last_dm_rdata = rd_val(16'h0300);
    bus.if_req = 1'b0;
    bus.dm_req = 1'b0;
  endtask

  task automatic test_capture();
    exp_t e;
    @(negedge clk);
    bus.dm_req  = 1'b1;
    bus.dm_we   = 1'b0;
    bus.dm_addr = 16'h0040;
    #1;
    checks++;
    if (bus.dm_gnt !== 1'b1) begin
      failures++;
      $display("FAIL capture_gnt: got %b expected 1", bus.dm_gnt);
    end
    sb_q.push_back('{1'b1, rd_val(16'h0040)});
    @(negedge clk);
    bus.dm_addr = 16'h0999;
    bus.dm_we   = 1'b1;
    #1;
    checks++;
    if (bus.mem_addr !== 16'h0040 || bus.mem_we !== 1'b0) begin
      failures++;
      $display("FAIL capture_addr_t1: got addr=%h we=%b expected 0040 0", bus.mem_addr, bus.mem_we);
    end
    @(negedge clk);
    bus.dm_req = 1'b0;
    #1;
    checks++;
    if (bus.mem_addr !== 16'h0040 || bus.mem_en !== 1'b1) begin
      failures++;
      $display("FAIL capture_addr_t2: got addr=%h en=%b expected 0040 1", bus.mem_addr, bus.mem_en);
    end
    @(negedge clk);
    bus.dm_we = 1'b0;
    #1;
    checks++;
    if (bus.dm_valid !== 1'b1) begin
      failures++;
      $display("FAIL capture_valid: got %b expected 1", bus.dm_valid);
    end else begin
      e = sb_q.pop_front();
      checks++;
      if (bus.dm_rdata !== e.data) begin
        failures++;
        $display("FAIL capture_rdata: got %h expected %h", bus.dm_rdata, e.data);
      end
      last_dm_rdata = e.data;
    end
    @(negedge clk);
    #1;
    checks++;
    if (bus.dm_gnt !== 1'b0 || bus.dm_valid !== 1'b0 || bus.busy !== 1'b0) begin
      failures++;
      $display("FAIL capture_idle: got gnt=%b valid=%b busy=%b expected 0 0 0", bus.dm_gnt, bus.dm_valid, bus.busy);
    end
  endtask

  task automatic test_rst_mid();
    exp_t e;
    @(negedge clk);
    bus.dm_req  = 1'b1;
    bus.dm_we   = 1'b0;
    bus.dm_addr = 16'h0050;
    #1;
    checks++;
    if (bus.dm_gnt !== 1'b1) begin
      failures++;
      $display("FAIL rstmid_gnt: got %b expected 1", bus.dm_gnt);
    end
    @(negedge clk);
    #1;
    checks++;
    if (bus.mem_en !== 1'b1) begin
      failures++;
      $display("FAIL rstmid_in_access: got mem_en=%b expected 1", bus.mem_en);
    end
    rst = 1'b1;
    last_dm_rdata = 16'h0000;
    #1;
    checks++;
    if (outs !== 71'd0) begin
      failures++;
      $display("FAIL rstmid_outputs: got %h expected 0", outs);
    end
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      #1;
      checks++;
      if (outs !== 71'd0) begin
        failures++;
        $display("FAIL rstmid_held%0d: got %h expected 0", i, outs);
      end
    end
    @(negedge clk);
    rst         = 1'b0;
    bus.dm_addr = 16'h0060;
    #1;
    checks++;
    if (bus.dm_gnt !== 1'b1) begin
      failures++;
      $display("FAIL rstmid_regrant: got %b expected 1", bus.dm_gnt);
    end
    sb_q.push_back('{1'b1, rd_val(16'h0060)});
    for (int k = 1; k <= MEM_LAT; k++) begin
      @(negedge clk);
      bus.dm_req = 1'b0;
      #1;
      checks++;
      if (bus.mem_addr !== 16'h0060 || bus.dm_valid !== 1'b0) begin
        failures++;
        $display("FAIL rstmid_access%0d: got addr=%h valid=%b expected 0060 0", k, bus.mem_addr, bus.dm_valid);
      end
    end
    @(negedge clk);
    #1;
    checks++;
    if (bus.dm_valid !== 1'b1) begin
      failures++;
      $display("FAIL rstmid_valid: got %b expected 1", bus.dm_valid);
    end else begin
      e = sb_q.pop_front();
      checks++;
      if (bus.dm_rdata !== e.data) begin
        failures++;
        $display("FAIL rstmid_rdata: got %h expected %h", bus.dm_rdata, e.data);
      end
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst          = 1'b1;
    bus.if_req   = 1'b0;
    bus.if_addr  = '0;
    bus.dm_req   = 1'b0;
    bus.dm_we    = 1'b0;
    bus.dm_addr  = '0;
    bus.dm_wdata = '0;
    last_dm_rdata = '0;
    test_reset();
    test_if_fetch();
    test_store();
    test_streak();
    test_capture();
    test_rst_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
